tag_stripper: RTL and testbench

- Receive-side counterpart of the NMU tagger, placed directly upstream of the NIC ingress path.
- Removes the tag inserted by the far-end tagger from every packet. The tag size per packet comes from a per-tid config register.
- Re-packs the remaining bytes into a contiguous AXI stream and reports the extracted tag on a sideband.

---
 rtl/tag_stripper.sv | 272 +++++++++++++++++++++++++++
 tb/tb_tag_stripper.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_stripper.sv
// tag_stripper: removes the far-end tag from each packet and
// re-packs the remaining bytes into a contiguous AXI stream.
module tag_stripper #(
   parameter int AXIS_BUS_WIDTH    = 64,
   parameter int AXIS_ID_WIDTH     = 4,
   parameter int AXIS_DEST_WIDTH   = 0,
   parameter int MAX_PACKET_LENGTH = 1522,
   parameter int MIN_TAG_SIZE_BITS = 32,
   parameter int MAX_TAG_SIZE_BITS = 64,
   parameter int TAG_OFFSET_BYTES  = 12,
   localparam int NB   = AXIS_BUS_WIDTH / 8,
   localparam int IDW  = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH,
   localparam int DSW  = (AXIS_DEST_WIDTH < 1) ? 1 : AXIS_DEST_WIDTH,
   localparam int NUM_TAG_SIZES =
      (MAX_TAG_SIZE_BITS - MIN_TAG_SIZE_BITS) / 16 + 2,
   localparam int NUM_TAG_SIZES_LOG2 = $clog2(NUM_TAG_SIZES),
   localparam int CFGW = MAX_TAG_SIZE_BITS + NUM_TAG_SIZES_LOG2
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [AXIS_BUS_WIDTH-1:0]    axis_in_tdata,
   input  logic [IDW-1:0]               axis_in_tid,
   input  logic [DSW-1:0]               axis_in_tdest,
   input  logic [NB-1:0]                axis_in_tkeep,
   input  logic                         axis_in_tlast,
   input  logic                         axis_in_tvalid,
   output logic                         axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0]    axis_out_tdata,
   output logic [IDW-1:0]               axis_out_tid,
   output logic [DSW-1:0]               axis_out_tdest,
   output logic [NB-1:0]                axis_out_tkeep,
   output logic                         axis_out_tlast,
   output logic                         axis_out_tvalid,
   input  logic                         axis_out_tready,
   output logic [IDW-1:0]               strip_config_sel,
   input  logic [CFGW-1:0]              strip_config_regs,
   output logic [MAX_TAG_SIZE_BITS-1:0] extracted_tag,
   output logic                         extracted_tag_valid,
   output logic                         runt_err
);

   localparam int W   = AXIS_BUS_WIDTH;
   localparam int TW  = MAX_TAG_SIZE_BITS;
   localparam int ML  = NUM_TAG_SIZES_LOG2;
   localparam int OFF = TAG_OFFSET_BYTES;
   localparam int BCW = $clog2(NB) + 1;
   localparam int CW  = $clog2(MAX_PACKET_LENGTH + NB + 1);

   typedef enum logic [1:0] {
      S_FIRST,
      S_HDR,
      S_BODY,
      S_FLUSH
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [ML-1:0]   mode_q, mode_d;
   logic [IDW-1:0]  tid_q, tid_d;
   logic [DSW-1:0]  dest_q, dest_d;
   logic [W-1:0]    res_q, res_d;
   logic [BCW-1:0]  rcnt_q, rcnt_d;
   logic [TW-1:0]   acc_q, acc_d;
   logic [TW-1:0]   tag_q, tag_d;
   logic            tagv_q, tagv_d;
   logic            runt_q, runt_d;
   logic            rdy_en_q;
   logic [W-1:0]    odata_q, odata_d;
   logic [NB-1:0]   okeep_q, okeep_d;
   logic            olast_q, olast_d;
   logic            ovalid_q, ovalid_d;
   logic [IDW-1:0]  otid_q, otid_d;
   logic [DSW-1:0]  odest_q, odest_d;

   logic            first;
   logic [ML-1:0]   mode_cur;
   logic [IDW-1:0]  tid_cur;
   logic [DSW-1:0]  dest_cur;
   logic            load_ok;
   logic            in_fire;
   int              tbytes;
   int              tag_end;
   int              base;
   int              end_i;
   int              nbytes;
   int              n;
   int              total;
   int              mi;
   int              a_i;
   logic [W-1:0]    cmp;
   logic [2*W-1:0]  comb;
   logic [TW-1:0]   acc_nx;
   logic            unused_cfg;

   function automatic logic [NB-1:0] mask_of(input int c);
      logic [NB-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) m[i] = (i < c);
      return m;
   endfunction

   assign unused_cfg = ^strip_config_regs[TW-1:0];
   assign first      = (state_q == S_FIRST);
   assign mode_cur   = first ? strip_config_regs[CFGW-1 -: ML] : mode_q;
   assign tid_cur    = first ? axis_in_tid : tid_q;
   assign dest_cur   = first ? axis_in_tdest : dest_q;
   assign load_ok    = !ovalid_q || axis_out_tready;
   assign axis_in_tready = rdy_en_q && load_ok && (state_q != S_FLUSH);
   assign in_fire    = axis_in_tready && axis_in_tvalid;
   assign strip_config_sel = tid_cur;

   assign axis_out_tdata  = odata_q;
   assign axis_out_tkeep  = okeep_q;
   assign axis_out_tlast  = olast_q;
   assign axis_out_tvalid = ovalid_q;
   assign axis_out_tid    = otid_q;
   assign axis_out_tdest  = odest_q;
   assign extracted_tag       = tag_q;
   assign extracted_tag_valid = tagv_q;
   assign runt_err            = runt_q;

   // Classify the incoming beat: drop tag bytes, compact the rest, collect tag.
   always_comb begin
      mi      = int'(mode_cur);
      tbytes  = (mi == 0 || mi >= NUM_TAG_SIZES) ? 0
              : MIN_TAG_SIZE_BITS / 8 + 2 * (mi - 1);
      tag_end = OFF + tbytes;
      base    = int'(cnt_q);
      cmp     = '0;
      n       = 0;
      nbytes  = 0;
      a_i     = 0;
      acc_nx  = first ? '0 : acc_q;
      for (int b = 0; b < NB; b++) begin
         a_i = base + b;
         if (axis_in_tkeep[b]) begin
            nbytes = nbytes + 1;
            if (a_i >= OFF && a_i < tag_end) begin
               acc_nx = {acc_nx[TW-9:0], axis_in_tdata[b*8 +: 8]};
            end else begin
               cmp[n*8 +: 8] = axis_in_tdata[b*8 +: 8];
               n = n + 1;
            end
         end
      end
      end_i = base + nbytes;
      total = int'(rcnt_q) + n;
      comb  = {{W{1'b0}}, res_q} | ({{W{1'b0}}, cmp} << {rcnt_q, 3'b000});
   end

   // Next state, residual bookkeeping and output register loading.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      tid_d    = tid_q;
      dest_d   = dest_q;
      res_d    = res_q;
      rcnt_d   = rcnt_q;
      acc_d    = acc_q;
      tag_d    = tag_q;
      tagv_d   = 1'b0;
      runt_d   = 1'b0;
      ovalid_d = ovalid_q && !axis_out_tready;
      odata_d  = odata_q;
      okeep_d  = okeep_q;
      olast_d  = olast_q;
      otid_d   = otid_q;
      odest_d  = odest_q;
      if (in_fire) begin
         if (first) begin
            mode_d = mode_cur;
            tid_d  = axis_in_tid;
            dest_d = axis_in_tdest;
         end
         acc_d = acc_nx;
         if (tbytes > 0 && base < tag_end && end_i >= tag_end) begin
            tag_d  = acc_nx;
            tagv_d = 1'b1;
         end
         otid_d  = tid_cur;
         odest_d = dest_cur;
         if (axis_in_tlast) begin
            runt_d   = (tbytes > 0) && (end_i > OFF) && (end_i < tag_end);
            cnt_d    = '0;
            ovalid_d = 1'b1;
            odata_d  = comb[W-1:0];
            if (total > NB) begin
               okeep_d = '1;
               olast_d = 1'b0;
               res_d   = comb[2*W-1:W];
               rcnt_d  = BCW'(total - NB);
               state_d = S_FLUSH;
            end else begin
               okeep_d = mask_of(total);
               olast_d = 1'b1;
               res_d   = '0;
               rcnt_d  = '0;
               state_d = S_FIRST;
            end
         end else begin
            cnt_d   = CW'(end_i);
            state_d = (end_i >= tag_end) ? S_BODY : S_HDR;
            if (total >= NB) begin
               ovalid_d = 1'b1;
               odata_d  = comb[W-1:0];
               okeep_d  = '1;
               olast_d  = 1'b0;
               res_d    = comb[2*W-1:W];
               rcnt_d   = BCW'(total - NB);
            end else begin
               res_d  = comb[W-1:0];
               rcnt_d = BCW'(total);
            end
         end
      end else if (state_q == S_FLUSH && load_ok) begin
         ovalid_d = 1'b1;
         odata_d  = res_q;
         okeep_d  = mask_of(int'(rcnt_q));
         olast_d  = 1'b1;
         otid_d   = tid_q;
         odest_d  = dest_q;
         res_d    = '0;
         rcnt_d   = '0;
         state_d  = S_FIRST;
      end
   end

   // State and output registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= S_FIRST;
         cnt_q    <= '0;
         mode_q   <= '0;
         tid_q    <= '0;
         dest_q   <= '0;
         res_q    <= '0;
         rcnt_q   <= '0;
         acc_q    <= '0;
         tag_q    <= '0;
         tagv_q   <= 1'b0;
         runt_q   <= 1'b0;
         rdy_en_q <= 1'b0;
         odata_q  <= '0;
         okeep_q  <= '0;
         olast_q  <= 1'b0;
         ovalid_q <= 1'b0;
         otid_q   <= '0;
         odest_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         tid_q    <= tid_d;
         dest_q   <= dest_d;
         res_q    <= res_d;
         rcnt_q   <= rcnt_d;
         acc_q    <= acc_d;
         tag_q    <= tag_d;
         tagv_q   <= tagv_d;
         runt_q   <= runt_d;
         rdy_en_q <= 1'b1;
         odata_q  <= odata_d;
         okeep_q  <= okeep_d;
         olast_q  <= olast_d;
         ovalid_q <= ovalid_d;
         otid_q   <= otid_d;
         odest_q  <= odest_d;
      end
   end

endmodule

// File: tb/tb_tag_stripper.sv
// tb_tag_stripper: randomized scoreboard bench for tag_stripper.
// Expected beats come from a byte-list model of tag removal.
module tb_tag_stripper;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [63:0] in_data;
   logic [3:0]  in_tid;
   logic [0:0]  in_dest;
   logic [7:0]  in_keep;
   logic        in_last;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_data;
   logic [3:0]  out_tid;
   logic [0:0]  out_dest;
   logic [7:0]  out_keep;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  cfg_sel;
   logic [65:0] cfg_regs;
   logic [63:0] tag;
   logic        tag_v;
   logic        runt;

   logic [1:0]  cfg_mode [16];

   always #5 aclk = ~aclk;

   assign cfg_regs = {cfg_mode[cfg_sel], 64'hA5A5_0F0F_1234_5678};

   tag_stripper dut (
      .aclk                (aclk),
      .aresetn             (aresetn),
      .axis_in_tdata       (in_data),
      .axis_in_tid         (in_tid),
      .axis_in_tdest       (in_dest),
      .axis_in_tkeep       (in_keep),
      .axis_in_tlast       (in_last),
      .axis_in_tvalid      (in_valid),
      .axis_in_tready      (in_ready),
      .axis_out_tdata      (out_data),
      .axis_out_tid        (out_tid),
      .axis_out_tdest      (out_dest),
      .axis_out_tkeep      (out_keep),
      .axis_out_tlast      (out_last),
      .axis_out_tvalid     (out_valid),
      .axis_out_tready     (out_ready),
      .strip_config_sel    (cfg_sel),
      .strip_config_regs   (cfg_regs),
      .extracted_tag       (tag),
      .extracted_tag_valid (tag_v),
      .runt_err            (runt)
   );

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic [3:0]  id;
      logic        ds;
   } beat_t;

   beat_t       exp_q[$];
   logic [63:0] tag_q[$];
   logic [7:0]  pkt[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_runt = 0;
   int          got_runt = 0;
   logic [63:0] last_tag = 64'h0;
   int          stall_mode = 0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   // Reference: delete bytes [12, 12+T) and chop what remains into beats.
   task automatic model(input int len, input int mode,
                        input int tid, input int dst);
      logic [7:0]  ob[$];
      int          t;
      logic [63:0] tv;
      beat_t       e;
      t = (mode == 0) ? 0 : (32 + 16 * (mode - 1)) / 8;
      for (int i = 0; i < len; i++)
         if (!(i >= 12 && i < 12 + t)) ob.push_back(pkt[i]);
      for (int k = 0; k < ob.size(); k += 8) begin
         e.d  = 64'h0;
         e.k  = 8'h0;
         for (int j = 0; j < 8 && k + j < ob.size(); j++) begin
            e.d[j*8 +: 8] = ob[k+j];
            e.k[j] = 1'b1;
         end
         e.l  = (k + 8 >= ob.size());
         e.id = 4'(tid);
         e.ds = 1'(dst);
         exp_q.push_back(e);
      end
      if (t > 0 && len >= 12 + t) begin
         tv = 64'h0;
         for (int i = 12; i < 12 + t; i++) tv = (tv << 8) | 64'(pkt[i]);
         tag_q.push_back(tv);
         last_tag = tv;
      end
      if (t > 0 && len > 12 && len < 12 + t) exp_runt++;
   endtask

   task automatic send_pkt(input int len, input int mode, input int tid,
                           input int dst, input bit gaps, input bit chk_sel);
      int tmo;
      cfg_mode[tid] = 2'(mode);
      model(len, mode, tid, dst);
      for (int k = 0; k < len; k += 8) begin
         if (gaps && ($urandom % 4 == 0)) begin
            in_valid = 1'b0;
            @(posedge aclk);
            #1;
         end
         in_data = 64'h0;
         in_keep = 8'h0;
         for (int j = 0; j < 8 && k + j < len; j++) begin
            in_data[j*8 +: 8] = pkt[k+j];
            in_keep[j] = 1'b1;
         end
         in_last  = (k + 8 >= len);
         in_tid   = 4'(tid);
         in_dest  = 1'(dst);
         in_valid = 1'b1;
         tmo = 0;
         @(negedge aclk);
         if (chk_sel && k == 0) chk("config_sel", 64'(cfg_sel), 64'(tid));
         while (!in_ready && tmo < 1000) begin
            @(negedge aclk);
            tmo++;
         end
         if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got 0 exp 1");
         end
         @(posedge aclk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge aclk);
         t++;
      end
      repeat (2) @(posedge aclk);
      #1;
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   // Output backpressure source.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         case (stall_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom % 2);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every accepted beat and tag pulse.
   initial begin
      beat_t       e;
      bit          stalled;
      logic [63:0] sd;
      logic [7:0]  sk;
      logic        sl;
      logic [63:0] gd;
      logic [63:0] xd;
      stalled = 1'b0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            stalled = 1'b0;
         end else begin
            if (stalled && out_valid) begin
               checks++;
               if (out_data !== sd || out_keep !== sk || out_last !== sl) begin
                  errors++;
                  $display("FAIL stall_stable got %h/%h/%b exp %h/%h/%b",
                           out_data, out_keep, out_last, sd, sk, sl);
               end
            end
            if (out_valid && out_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL extra_beat got %h exp none", out_data);
               end else begin
                  e = exp_q.pop_front();
                  gd = 64'h0;
                  xd = 64'h0;
                  for (int i = 0; i < 8; i++)
                     if (e.k[i]) begin
                        gd[i*8 +: 8] = out_data[i*8 +: 8];
                        xd[i*8 +: 8] = e.d[i*8 +: 8];
                     end
                  if (gd !== xd || out_keep !== e.k || out_last !== e.l ||
                      out_tid !== e.id || out_dest[0] !== e.ds) begin
                     errors++;
                     $display("FAIL beat got d=%h k=%h l=%b id=%h ds=%b exp d=%h k=%h l=%b id=%h ds=%b",
                              gd, out_keep, out_last, out_tid, out_dest,
                              xd, e.k, e.l, e.id, e.ds);
                  end
               end
            end
            stalled = out_valid && !out_ready;
            sd = out_data;
            sk = out_keep;
            sl = out_last;
            if (tag_v) begin
               checks++;
               if (tag_q.size() == 0) begin
                  errors++;
                  $display("FAIL extra_tag_pulse got %h exp none", tag);
               end else begin
                  xd = tag_q.pop_front();
                  if (tag !== xd) begin
                     errors++;
                     $display("FAIL tag got %h exp %h", tag, xd);
                  end
               end
            end
            if (runt) got_runt++;
         end
      end
   end

   task automatic rand_bytes(input int len);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
   endtask

   initial begin
      int len;
      int tmo;
      for (int i = 0; i < 16; i++) cfg_mode[i] = 2'd0;
      aresetn  = 1'b0;
      in_data  = 64'h0;
      in_tid   = 4'h0;
      in_dest  = 1'b0;
      in_keep  = 8'h0;
      in_last  = 1'b0;
      in_valid = 1'b0;
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      chk("rst_keep",      64'(out_keep),  64'd0);
      chk("rst_last",      64'(out_last),  64'd0);
      chk("rst_tag_v",     64'(tag_v),     64'd0);
      chk("rst_runt",      64'(runt),      64'd0);
      chk("rst_tag",       tag,            64'd0);
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;

      // Mode 0, tid 5: passes unchanged.
      rand_bytes(24);
      send_pkt(24, 0, 5, 0, 1'b0, 1'b1);
      drain();

      // Mode 1 with a known tag.
      rand_bytes(68);
      pkt[12] = 8'hDE;
      pkt[13] = 8'hAD;
      pkt[14] = 8'hBE;
      pkt[15] = 8'hEF;
      send_pkt(68, 1, 3, 1, 1'b0, 1'b0);
      drain();
      chk("tag_deadbeef", tag, 64'h0000_0000_DEAD_BEEF);

      // Mode 3, 70 bytes.
      rand_bytes(70);
      send_pkt(70, 3, 7, 0, 1'b0, 1'b0);
      drain();

      // Mode 2 runt.
      rand_bytes(16);
      send_pkt(16, 2, 2, 0, 1'b0, 1'b0);
      drain();
      chk("runt_count", 64'(got_runt), 64'd1);

      // Random traffic with random backpressure.
      stall_mode = 1;
      for (int p = 0; p < 40; p++) begin
         len = ($urandom % 2 == 0) ? $urandom_range(1, 24)
                                   : $urandom_range(25, 100);
         rand_bytes(len);
         send_pkt(len, $urandom_range(0, 3), $urandom_range(0, 15),
                  $urandom_range(0, 1), 1'b1, 1'b0);
      end
      drain();

      // Reset in the middle of a packet.
      stall_mode = 2;
      repeat (2) @(posedge aclk);
      #1;
      cfg_mode[9] = 2'd1;
      in_data  = 64'h0102_0304_0506_0708;
      in_keep  = 8'hFF;
      in_last  = 1'b0;
      in_tid   = 4'd9;
      in_dest  = 1'b0;
      in_valid = 1'b1;
      tmo = 0;
      @(negedge aclk);
      while (!in_ready && tmo < 100) begin
         @(negedge aclk);
         tmo++;
      end
      @(posedge aclk);
      #1;
      in_valid = 1'b0;
      @(posedge aclk);
      #1;
      aresetn = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready",  64'(in_ready),  64'd0);
      chk("mid_rst_keep",      64'(out_keep),  64'd0);
      chk("mid_rst_last",      64'(out_last),  64'd0);
      chk("mid_rst_tag_v",     64'(tag_v),     64'd0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      stall_mode = 1;
      in_tid = 4'd11;
      #1;
      chk("post_rst_sel", 64'(cfg_sel), 64'd11);
      @(posedge aclk);
      #1;
      rand_bytes(60);
      send_pkt(60, 1, 11, 1, 1'b0, 1'b1);
      drain();

      chk("tag_left",    64'(tag_q.size()), 64'd0);
      chk("runt_total",  64'(got_runt),     64'(exp_runt));
      chk("tag_held",    tag,               last_tag);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
